// File: rtl/job_seq_pkg.sv
// Shared definitions for the matrix-vector job sequencer: one-hot state
// encodings and default field widths.
package job_seq_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int TO_W_DEF  = 20;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_MATW  = 5'b00010,
      ST_RUN   = 5'b00100,
      ST_DRAIN = 5'b01000,
      ST_DONE  = 5'b10000
   } state_e;

   // States in which handshake activity is expected and the watchdog runs.
   function automatic logic is_active(input state_e s);
      return (s == ST_MATW) || (s == ST_RUN) || (s == ST_DRAIN);
   endfunction

endpackage

// File: rtl/job_seq_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles without activity and flags the
// cycle whose increment would reach TIMEOUT.
module job_watchdog #(
   parameter int             TO_W    = 20,
   parameter logic [TO_W-1:0] TIMEOUT = {TO_W{1'b1}}
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic expire
);

   localparam logic [TO_W-1:0] LIM = TIMEOUT - 1'b1;

   logic [TO_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || !en) cnt_d = '0;
   end

   assign expire = en && !clr && (cnt_q == LIM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/job_seq.sv
// Job sequencer: matrix load, N source batches, drain of result streams.
// Drives the matw/run/last mode bits and reports busy/done/err.
module job_seq
   import job_seq_pkg::*;
#(
   parameter int              CNT_W   = CNT_W_DEF,
   parameter int              TO_W    = TO_W_DEF,
   parameter logic [TO_W-1:0] TIMEOUT = {TO_W{1'b1}}
) (
   input  logic             AXIS_ACLK,
   input  logic             AXIS_ARESETN,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] cfg_mat_beats,
   input  logic [CNT_W-1:0] cfg_batches,
   input  logic             in_beat,
   input  logic             src_fin,
   input  logic             out_last,
   output logic             matw,
   output logic             run,
   output logic             last,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] batch_in_cnt,
   output logic [CNT_W-1:0] batch_out_cnt
);

   function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_e           state_q, state_d;
   logic [CNT_W-1:0] mat_beats_q, mat_beats_d;
   logic [CNT_W-1:0] batches_q, batches_d;
   logic [CNT_W-1:0] mat_cnt_q, mat_cnt_d;
   logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic             err_q, err_d;
   logic             matw_q, run_q, last_q, busy_q, done_q;
   logic             activity, wd_expire;

   assign activity = in_beat | src_fin | out_last;

   job_watchdog #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_wd (
      .clk    (AXIS_ACLK),
      .rst_n  (AXIS_ARESETN),
      .en     (is_active(state_q)),
      .clr    (activity),
      .expire (wd_expire)
   );

   always_comb begin
      state_d     = state_q;
      mat_beats_d = mat_beats_q;
      batches_d   = batches_q;
      mat_cnt_d   = mat_cnt_q;
      in_cnt_d    = in_cnt_q;
      out_cnt_d   = out_cnt_q;
      err_d       = err_q;
      // abort beats everything, including a watchdog expiry in the same cycle
      if (abort) begin
         state_d = ST_IDLE;
      end else if (wd_expire) begin
         state_d = ST_IDLE;
         err_d   = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start && (cfg_batches != '0)) begin
                  mat_beats_d = cfg_mat_beats;
                  batches_d   = cfg_batches;
                  mat_cnt_d   = '0;
                  in_cnt_d    = '0;
                  out_cnt_d   = '0;
                  err_d       = 1'b0;
                  state_d     = (cfg_mat_beats != '0) ? ST_MATW : ST_RUN;
               end
            end
            ST_MATW: begin
               if (in_beat) begin
                  mat_cnt_d = inc_sat(mat_cnt_q);
                  if (mat_cnt_d == mat_beats_q) state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (out_last && (out_cnt_q != batches_q)) out_cnt_d = inc_sat(out_cnt_q);
               if (src_fin) begin
                  in_cnt_d = inc_sat(in_cnt_q);
                  if (in_cnt_d == batches_q) state_d = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (out_last && (out_cnt_q != batches_q)) out_cnt_d = inc_sat(out_cnt_q);
               // outputs may already be complete on entry; leave on the first drain cycle
               if (out_cnt_d == batches_q) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         state_q     <= ST_IDLE;
         mat_beats_q <= '0;
         batches_q   <= '0;
         mat_cnt_q   <= '0;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         err_q       <= 1'b0;
         matw_q      <= 1'b0;
         run_q       <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mat_beats_q <= mat_beats_d;
         batches_q   <= batches_d;
         mat_cnt_q   <= mat_cnt_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         err_q       <= err_d;
         matw_q      <= (state_d == ST_MATW);
         run_q       <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
         last_q      <= (state_d == ST_DRAIN);
         busy_q      <= (state_d != ST_IDLE);
         done_q      <= (state_d == ST_DONE);
      end
   end

   assign matw          = matw_q;
   assign run           = run_q;
   assign last          = last_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
   assign batch_in_cnt  = in_cnt_q;
   assign batch_out_cnt = out_cnt_q;

endmodule
